// File: rtl/banco_registros_param_if.sv
// banco_registros_param_if
//   Bus bundle for the parametrised register bank: write port, two read
//   addresses, bulk-clear request and the returned read data / status.
//   master : drives Entrada, HabilitarEscritura, DireccionEscritura,
//            DireccionA, DireccionB, Limpiar; observes SalidaA, SalidaB,
//            Ocupado, EscrituraIgnorada.
//   slave  : the register bank side (mirror of master).
interface banco_registros_param_if #(
   parameter int ANCHO     = 16,
   parameter int ANCHO_DIR = 3
);
   logic [ANCHO-1:0]     Entrada;
   logic                 HabilitarEscritura;
   logic [ANCHO_DIR-1:0] DireccionEscritura;
   logic [ANCHO_DIR-1:0] DireccionA;
   logic [ANCHO_DIR-1:0] DireccionB;
   logic                 Limpiar;
   logic [ANCHO-1:0]     SalidaA;
   logic [ANCHO-1:0]     SalidaB;
   logic                 Ocupado;
   logic                 EscrituraIgnorada;

   modport master (
      output Entrada, HabilitarEscritura, DireccionEscritura,
             DireccionA, DireccionB, Limpiar,
      input  SalidaA, SalidaB, Ocupado, EscrituraIgnorada
   );

   modport slave (
      input  Entrada, HabilitarEscritura, DireccionEscritura,
             DireccionA, DireccionB, Limpiar,
      output SalidaA, SalidaB, Ocupado, EscrituraIgnorada
   );
endinterface

// File: rtl/banco_registros_param.sv
// banco_registros_param
//   Parametrised register file: two combinational read ports, one
//   synchronous write port with write-to-read bypass, asynchronous
//   active-low reset of contents, and a sequential bulk-clear engine
//   (one entry per clock, ascending) with a busy flag.
//   Ports:
//     Reloj     - clock, all state changes on the rising edge
//     Reiniciar - asynchronous active-low reset
//     bus       - banco_registros_param_if.slave (write/read/clear bus)
//   Optional build macro BANCO_R0_CERO_EN: entry 0 reads as zero, writes
//   to it are dropped silently and it never bypasses.
module banco_registros_param #(
   parameter int ANCHO       = 16,
   parameter int PROFUNDIDAD = 8,
   parameter int ANCHO_DIR   = 3
) (
   input logic                     Reloj,
   input logic                     Reiniciar,
   banco_registros_param_if.slave  bus
);

`ifdef BANCO_R0_CERO_EN
   localparam bit R0_CERO = 1'b1;
`else
   localparam bit R0_CERO = 1'b0;
`endif

   localparam logic [ANCHO_DIR:0] LIMITE = (ANCHO_DIR+1)'(PROFUNDIDAD);
   localparam logic [ANCHO_DIR:0] ULTIMO = (ANCHO_DIR+1)'(PROFUNDIDAD-1);

   typedef enum logic {REPOSO, LIMPIANDO} estado_t;

   estado_t              estado, estadoSig;
   logic [ANCHO_DIR:0]   indice;
   logic [ANCHO-1:0]     memoria [PROFUNDIDAD];
   logic                 escrituraIgnoradaQ;

   logic                 direccionEscribible;
   logic                 escrituraAceptada;
   logic                 escrituraDescartada;
   logic [PROFUNDIDAD-1:0] escribirEntrada;
   logic [PROFUNDIDAD-1:0] limpiarEntrada;
   logic [ANCHO-1:0]     valorA, valorB;

   // A write targets a real, writable entry (in range, and not a
   // hardwired entry 0); anything else is dropped without a pulse.
   always_comb begin
      direccionEscribible = ({1'b0, bus.DireccionEscritura} < LIMITE) &&
                            !(R0_CERO && (bus.DireccionEscritura == '0));
      escrituraAceptada   = bus.HabilitarEscritura && direccionEscribible &&
                            (estado == REPOSO);
      escrituraDescartada = bus.HabilitarEscritura && direccionEscribible &&
                            (estado == LIMPIANDO);
   end

   always_comb begin
      escribirEntrada = '0;
      limpiarEntrada  = '0;
      for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
         escribirEntrada[i] = escrituraAceptada &&
                              (bus.DireccionEscritura == i[ANCHO_DIR-1:0]);
         limpiarEntrada[i]  = (estado == LIMPIANDO) &&
                              (indice == (ANCHO_DIR+1)'(i));
      end
   end

   // FSM state register
   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         estado <= REPOSO;
      end else begin
         estado <= estadoSig;
      end
   end

   // FSM next state
   always_comb begin
      estadoSig = estado;
      case (estado)
         REPOSO: begin
            if (bus.Limpiar) estadoSig = LIMPIANDO;
         end
         LIMPIANDO: begin
            if (indice == ULTIMO) estadoSig = REPOSO;
         end
         default: estadoSig = REPOSO;
      endcase
   end

   // Sweep index: held at 0 while idle so the sweep always starts at entry 0.
   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         indice <= '0;
      end else if (estado == LIMPIANDO) begin
         indice <= indice + 1'b1;
      end else begin
         indice <= '0;
      end
   end

   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         escrituraIgnoradaQ <= 1'b0;
      end else begin
         escrituraIgnoradaQ <= escrituraDescartada;
      end
   end

   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         for (int unsigned i = 0; i < PROFUNDIDAD; i++) memoria[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
            if (limpiarEntrada[i]) begin
               memoria[i] <= '0;
            end else if (escribirEntrada[i]) begin
               memoria[i] <= bus.Entrada;
            end
         end
      end
   end

   // Reads: out-of-range addresses match no entry and fall through to 0.
   always_comb begin
      valorA = '0;
      for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
         if (bus.DireccionA == i[ANCHO_DIR-1:0]) valorA = memoria[i];
      end
      if (escrituraAceptada && (bus.DireccionA == bus.DireccionEscritura)) begin
         valorA = bus.Entrada;
      end
      if (R0_CERO && (bus.DireccionA == '0)) valorA = '0;
   end

   always_comb begin
      valorB = '0;
      for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
         if (bus.DireccionB == i[ANCHO_DIR-1:0]) valorB = memoria[i];
      end
      if (escrituraAceptada && (bus.DireccionB == bus.DireccionEscritura)) begin
         valorB = bus.Entrada;
      end
      if (R0_CERO && (bus.DireccionB == '0)) valorB = '0;
   end

   assign bus.SalidaA           = valorA;
   assign bus.SalidaB           = valorB;
   assign bus.Ocupado           = (estado == LIMPIANDO);
   assign bus.EscrituraIgnorada = escrituraIgnoradaQ;

endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
Parametrised multi-read register file and the next generation of the fixed 8x16 bank used by the ciscud datapath. Two asynchronous read ports and one synchronous write port, with write-to-read bypass and hardware reset of contents. Adds a sequential bulk-clear engine (Limpiar) with busy handshake, so the control unit can zero the bank without a reset. Sits between the decode stage (addresses) and the ALU/writeback path (data).

Parameters:
ANCHO, 16, data width in bits of each entry and of Entrada/SalidaA/SalidaB
PROFUNDIDAD, 8, number of entries; legal range 2..2**ANCHO_DIR
ANCHO_DIR, 3, width of all address ports

Ports:
Reloj  input  1  clock; all state changes on the rising edge
Reiniciar  input  1  asynchronous, active-low reset
Entrada  input  ANCHO  write data
HabilitarEscritura  input  1  write enable, sampled on the rising edge of Reloj
DireccionEscritura  input  ANCHO_DIR  write address
DireccionA  input  ANCHO_DIR  read address, port A
DireccionB  input  ANCHO_DIR  read address, port B
Limpiar  input  1  bulk-clear request, sampled on the rising edge of Reloj
SalidaA  output  ANCHO  read data, port A (combinational)
SalidaB  output  ANCHO  read data, port B (combinational)
Ocupado  output  1  high while a bulk clear is in progress
EscrituraIgnorada  output  1  registered one-cycle pulse: a write was dropped

Behaviour:
- Reset: Reiniciar=0 asynchronously zeroes all entries, FSM to REPOSO, index to 0, Ocupado=0, EscrituraIgnorada=0. SalidaA/B therefore read 0 while reset is held.
- FSM states: REPOSO and LIMPIANDO.
- REPOSO:
  - A write with HabilitarEscritura=1 stores Entrada at DireccionEscritura on the edge.
  - Limpiar=1 on edge N moves the FSM to LIMPIANDO, sets index=0 and Ocupado=1 after edge N.
  - A write on the same edge N is still performed.
- LIMPIANDO:
  - Edges N+1..N+PROFUNDIDAD zero entries 0..PROFUNDIDAD-1, one entry per edge, in ascending order.
  - On edge N+PROFUNDIDAD the last entry is cleared, the FSM returns to REPOSO and Ocupado falls. Ocupado is high for exactly PROFUNDIDAD cycles.
  - Limpiar is ignored while in LIMPIANDO; there is no queueing and no restart.
  - Any HabilitarEscritura=1 is dropped. EscrituraIgnorada=1 in the cycle after that edge.
- Reads:
  - Combinational from the array.
  - Bypass applies only in REPOSO: if HabilitarEscritura=1 and the read address equals DireccionEscritura, the port outputs Entrada in the same cycle.
  - No bypass in LIMPIANDO. An entry not yet cleared returns its old value; an entry already cleared returns 0.
- Out-of-range addresses (>= PROFUNDIDAD): a write is dropped silently (EscrituraIgnorada stays 0); a read returns 0; no bypass.
- Both read ports may address the same entry, or the write entry, simultaneously, with no conflict.
- Reset asserted mid-sweep: the sweep aborts immediately, all entries are 0, and the FSM is in REPOSO after reset release.
- Index counter is ANCHO_DIR+1 bits wide, so that PROFUNDIDAD=2**ANCHO_DIR terminates without wrap-around.

Optional Feature:
Macro BANCO_R0_CERO_EN.
- Defined: entry 0 is hardwired to 0. Reads of address 0 return 0, with no bypass. Writes to address 0 are dropped silently (EscrituraIgnorada stays 0). The sweep timing is unchanged, and the clear of entry 0 is a no-op.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Pulse Reiniciar=0 mid-operation after writes -> all addresses read 0x0000 on A and B; Ocupado=0, EscrituraIgnorada=0.
- Write 0x1234 to addr 3 and 0xBEEF to addr 7, then read A=3, B=7 -> SalidaA=0x1234, SalidaB=0xBEEF; set A=B=7 -> both read 0xBEEF.
- Bypass in REPOSO: addr 5 holds 0x0001; in the same cycle write 0xA5A5 to addr 5 with A=5 -> SalidaA=0xA5A5 before the edge and after it.
- Fill all 8 entries, then pulse Limpiar for 1 cycle -> Ocupado high for exactly 8 cycles; entry k reads 0 from edge N+1+k; all entries read 0 at the end.
- Write 0x7777 to addr 2 two cycles into the sweep -> write dropped, EscrituraIgnorada pulses once, addr 2 reads 0 at the end; a second Limpiar during the sweep is ignored (Ocupado length still 8).
- Assert Reiniciar during cycle 4 of the sweep -> Ocupado=0 at once and all entries 0. Then, with BANCO_R0_CERO_EN defined, write 0xFFFF to addr 0 -> reads 0x0000, EscrituraIgnorada stays 0.
